// File: rtl/divider_iter_pkg.sv
// Shared definitions for the iterative radix-2 restoring divider.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package divider_iter_pkg;

    // Controller states. The encoding is fixed so that it stays stable
    // across tools and in waveform viewers.
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        FIX  = 2'd2,
        DONE = 2'd3
    } state_t;

    localparam int M_DEFAULT = 26;
    localparam int N_DEFAULT = 14;

    // The iteration counter holds M-1 down to 0. clog2(M) bits are enough
    // for that. The floor of 1 bit covers the degenerate M=2 case.
    function automatic int cnt_width(input int m);
        return (m <= 2) ? 1 : $clog2(m);
    endfunction

    localparam int CNT_W_DEFAULT = cnt_width(M_DEFAULT);

endpackage

// File: rtl/divider_iter_step.sv
// One radix-2 restoring-division iteration: shift, trial-subtract, restore.
// Latency: purely combinational.
// Backpressure: none; the caller decides when to register the result.
//
// Ports:
//   rem_in  : partial remainder (N+1 bits)
//   bit_in  : next dividend bit, MSB first
//   dvs     : divisor magnitude (N bits, unsigned)
//   rem_out : updated partial remainder
//   q_bit   : quotient bit produced by this iteration
import divider_iter_pkg::*;

module divider_iter_step #(
    parameter int N = N_DEFAULT
) (
    input  logic [N:0]   rem_in,
    input  logic         bit_in,
    input  logic [N-1:0] dvs,
    output logic [N:0]   rem_out,
    output logic         q_bit
);

    logic [N:0] shifted;
    logic [N:0] diff;

    // The partial remainder is always below dvs. That means rem_in[N] is 0
    // in practice and the shift cannot overflow N+1 bits. The top bit still
    // feeds the compare, so the block stays correct for any input.
    assign shifted = {rem_in[N-1:0], bit_in};
    assign diff    = shifted - {1'b0, dvs};
    assign q_bit   = rem_in[N] | (shifted >= {1'b0, dvs});
    assign rem_out = q_bit ? diff : shifted;

endmodule

// File: rtl/divider_iter.sv
// Multi-cycle signed/unsigned M/N-bit restoring divider with remainder and flags.
// Latency: out_valid M+2 edges after accept (accept edge included), 1 edge on divide-by-zero.
// Backpressure: result held in DONE until out_ready; in_ready is low outside IDLE.
//
// Ports:
//   clk, rst_n            : clock, async active-low reset
//   in_valid/in_ready     : operand handshake (signed_mode, dividend, divisor)
//   out_valid/out_ready   : result handshake (quotient, remainder, div_zero, ovf)
import divider_iter_pkg::*;

module divider_iter #(
    parameter int M = M_DEFAULT,
    parameter int N = N_DEFAULT
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic         signed_mode,
    input  logic [M-1:0] dividend,
    input  logic [N-1:0] divisor,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [M-1:0] quotient,
    output logic [N-1:0] remainder,
    output logic         div_zero,
    output logic         ovf
);

    localparam int CW = cnt_width(M);

    state_t         state;
    logic           sm_r;
    logic           dvd_neg_r;
    logic           dvs_neg_r;
    logic           ovf_pend_r;
    logic [M-1:0]   q_sh_r;     // dividend bits shift out the top, quotient bits shift in below
    logic [N-1:0]   dvs_mag_r;
    logic [N:0]     rem_r;
    logic [CW-1:0]  cnt_r;

    logic           dvd_neg;
    logic           dvs_neg;
    logic [M-1:0]   dvd_mag;
    logic [N-1:0]   dvs_mag;
    logic           is_ovf;
    logic [N:0]     rem_nxt;
    logic           q_bit;
    logic [M-1:0]   q_fix;
    logic [N-1:0]   r_fix;

    // Operand conditioning at accept. Negating -2^(M-1) yields 2^(M-1),
    // which is the correct unsigned magnitude in M bits.
    assign dvd_neg = signed_mode & dividend[M-1];
    assign dvs_neg = signed_mode & divisor[N-1];
    assign dvd_mag = dvd_neg ? -dividend : dividend;
    assign dvs_mag = dvs_neg ? -divisor  : divisor;
    assign is_ovf  = signed_mode
                   & (dividend == {1'b1, {(M-1){1'b0}}})
                   & (divisor == {N{1'b1}});

    divider_iter_step #(.N(N)) u_step (
        .rem_in  (rem_r),
        .bit_in  (q_sh_r[M-1]),
        .dvs     (dvs_mag_r),
        .rem_out (rem_nxt),
        .q_bit   (q_bit)
    );

    // Truncating division: the quotient sign is the XOR of the operand
    // signs, and the remainder follows the dividend. In the overflow case
    // the magnitude quotient is 2^(M-1) and the signs match. The result
    // therefore already reads as the most-negative value with remainder 0.
    assign q_fix = (sm_r & (dvd_neg_r ^ dvs_neg_r)) ? -q_sh_r : q_sh_r;
    assign r_fix = (sm_r & dvd_neg_r) ? -rem_r[N-1:0] : rem_r[N-1:0];

    assign in_ready  = (state == IDLE);
    assign out_valid = (state == DONE);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            sm_r       <= 1'b0;
            dvd_neg_r  <= 1'b0;
            dvs_neg_r  <= 1'b0;
            ovf_pend_r <= 1'b0;
            q_sh_r     <= '0;
            dvs_mag_r  <= '0;
            rem_r      <= '0;
            cnt_r      <= '0;
            quotient   <= '0;
            remainder  <= '0;
            div_zero   <= 1'b0;
            ovf        <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        sm_r       <= signed_mode;
                        dvd_neg_r  <= dvd_neg;
                        dvs_neg_r  <= dvs_neg;
                        ovf_pend_r <= is_ovf;
                        q_sh_r     <= dvd_mag;
                        dvs_mag_r  <= dvs_mag;
                        rem_r      <= '0;
                        cnt_r      <= CW'(M - 1);
                        if (divisor == '0) begin
                            quotient  <= '1;
                            remainder <= '0;
                            div_zero  <= 1'b1;
                            ovf       <= 1'b0;
                            state     <= DONE;
                        end else begin
                            state <= CALC;
                        end
                    end
                end
                CALC: begin
                    rem_r  <= rem_nxt;
                    q_sh_r <= {q_sh_r[M-2:0], q_bit};
                    if (cnt_r == '0) begin
                        state <= FIX;
                    end else begin
                        cnt_r <= cnt_r - CW'(1);
                    end
                end
                FIX: begin
                    quotient  <= q_fix;
                    remainder <= r_fix;
                    div_zero  <= 1'b0;
                    ovf       <= ovf_pend_r;
                    state     <= DONE;
                end
                DONE: begin
                    if (out_ready) begin
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_divider_iter.sv
// Self-checking bench for divider_iter (M=26, N=14).
// A stimulus process pushes hand-computed expectations into a queue.
// A monitor process pops and compares them on every consumed result.
`timescale 1ns/1ps

module tb_divider_iter;

    localparam int M = 26;
    localparam int N = 14;

    typedef struct packed {
        logic [M-1:0] q;
        logic [N-1:0] r;
        logic         dz;
        logic         ov;
    } exp_t;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         in_valid = 1'b0;
    logic         in_ready;
    logic         signed_mode = 1'b0;
    logic [M-1:0] dividend = '0;
    logic [N-1:0] divisor = '0;
    logic         out_valid;
    logic         out_ready = 1'b1;
    logic [M-1:0] quotient;
    logic [N-1:0] remainder;
    logic         div_zero;
    logic         ovf;

    exp_t sb[$];
    int   n_cmp = 0;
    int   n_bad = 0;

    always #5 clk = ~clk;

    divider_iter #(.M(M), .N(N)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .signed_mode (signed_mode),
        .dividend    (dividend),
        .divisor     (divisor),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .quotient    (quotient),
        .remainder   (remainder),
        .div_zero    (div_zero),
        .ovf         (ovf)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Monitor: every consumed result is checked against the oldest expectation.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (rst_n && out_valid && out_ready) begin
                if (sb.size() == 0) begin
                    check("unexpected_result", 32'd1, 32'd0);
                end else begin
                    e = sb.pop_front();
                    check("quotient",  32'(quotient),  32'(e.q));
                    check("remainder", 32'(remainder), 32'(e.r));
                    check("div_zero",  32'(div_zero),  32'(e.dz));
                    check("ovf",       32'(ovf),       32'(e.ov));
                end
            end
        end
    end

    // Drives one operand set, records the expectation, returns just after the accept edge.
    task automatic issue(input logic sm, input logic [M-1:0] a, input logic [N-1:0] b,
                         input logic [M-1:0] eq, input logic [N-1:0] er,
                         input logic edz, input logic eov);
        int k = 0;
        exp_t e;
        @(negedge clk);
        while (!in_ready && k < 200) begin
            @(negedge clk);
            k++;
        end
        check("in_ready_before_issue", 32'(in_ready), 32'd1);
        signed_mode = sm;
        dividend    = a;
        divisor     = b;
        in_valid    = 1'b1;
        e.q = eq; e.r = er; e.dz = edz; e.ov = eov;
        sb.push_back(e);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    // Measures edges from accept (inclusive) to out_valid.
    task automatic wait_done(input string name, input int exp_lat);
        int e = 0;
        while (!out_valid && e < 200) begin
            @(posedge clk);
            #1;
            e++;
        end
        check(name, 32'(e + 1), 32'(exp_lat));
    endtask

    task automatic wait_consumed();
        int k = 0;
        while (out_valid && k < 200) begin
            @(posedge clk);
            #1;
            k++;
        end
        check("consumed", 32'(out_valid), 32'd0);
    endtask

    task automatic run(input string name, input logic sm, input logic [M-1:0] a,
                       input logic [N-1:0] b, input logic [M-1:0] eq, input logic [N-1:0] er,
                       input logic edz, input logic eov, input int lat);
        issue(sm, a, b, eq, er, edz, eov);
        wait_done(name, lat);
        wait_consumed();
    endtask

    initial begin
        int k;
        // Reset state
        #2;
        check("rst_in_ready",  32'(in_ready),  32'd1);
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_quotient",  32'(quotient),  32'd0);
        check("rst_remainder", 32'(remainder), 32'd0);
        check("rst_flags",     32'({div_zero, ovf}), 32'd0);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;

        // Fixed-point ratio: (0x9D6 << 14) / 0x0B4B
        run("lat_unsigned", 1'b0, 26'd41254912, 14'd2891, 26'd14270, 14'd342, 1'b0, 1'b0, M + 2);
        // Signed truncating division
        run("lat_neg_dvd", 1'b1, 26'h3FFFF9C, 14'd7,    26'h3FFFFF2, 14'h3FFE, 1'b0, 1'b0, M + 2);
        run("lat_neg_dvs", 1'b1, 26'd100,     14'h3FF9, 26'h3FFFFF2, 14'd2,    1'b0, 1'b0, M + 2);
        // Divide by zero, unsigned and signed
        run("lat_div0",    1'b0, 26'd1234, 14'd0, 26'h3FFFFFF, 14'd0, 1'b1, 1'b0, 1);
        run("lat_div0_s",  1'b1, 26'h3FFFFFB, 14'd0, 26'h3FFFFFF, 14'd0, 1'b1, 1'b0, 1);
        // Signed overflow, then the same bits read as unsigned: 2^25 = 16383*2048 + 2048
        run("lat_ovf",     1'b1, 26'h2000000, 14'h3FFF, 26'h2000000, 14'd0,    1'b0, 1'b1, M + 2);
        run("lat_ovf_u",   1'b0, 26'h2000000, 14'h3FFF, 26'd2048,    14'd2048, 1'b0, 1'b0, M + 2);
        // Full-scale unsigned, and a small dividend over a larger divisor
        run("lat_max",     1'b0, 26'h3FFFFFF, 14'd1,    26'h3FFFFFF, 14'd0, 1'b0, 1'b0, M + 2);
        run("lat_small",   1'b0, 26'd5,       14'd9,    26'd0,       14'd5, 1'b0, 1'b0, M + 2);

        // Backpressure: 1000/7 = 142 r 6. Extra in_valid during CALC and DONE must be ignored.
        out_ready = 1'b0;
        issue(1'b0, 26'd1000, 14'd7, 26'd142, 14'd6, 1'b0, 1'b0);
        in_valid = 1'b1;
        dividend = 26'd999;
        divisor  = 14'd1;
        wait_done("lat_bp", M + 2);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            dividend = 26'(i * 37 + 11);
            check("bp_out_valid", 32'(out_valid), 32'd1);
            check("bp_in_ready",  32'(in_ready),  32'd0);
            check("bp_quotient",  32'(quotient),  32'd142);
            check("bp_remainder", 32'(remainder), 32'd6);
        end
        @(posedge clk);
        #1;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        check("bp_release_in_ready",  32'(in_ready),  32'd1);
        check("bp_release_out_valid", 32'(out_valid), 32'd0);
        check("bp_hold_quotient",     32'(quotient),  32'd142);
        // Back-to-back: -1000 / -3 = 333 r -1
        run("lat_b2b", 1'b1, 26'h3FFFC18, 14'h3FFD, 26'd333, 14'h3FFF, 1'b0, 1'b0, M + 2);

        // Reset in the middle of CALC discards the operation.
        @(negedge clk);
        signed_mode = 1'b0;
        dividend    = 26'd41254912;
        divisor     = 14'd2891;
        in_valid    = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        repeat (10) @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        check("mid_rst_out_valid", 32'(out_valid), 32'd0);
        check("mid_rst_in_ready",  32'(in_ready),  32'd1);
        check("mid_rst_quotient",  32'(quotient),  32'd0);
        check("mid_rst_remainder", 32'(remainder), 32'd0);
        check("mid_rst_flags",     32'({div_zero, ovf}), 32'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        run("lat_after_rst", 1'b0, 26'd1000, 14'd3, 26'd333, 14'd1, 1'b0, 1'b0, M + 2);

        k = 0;
        while (sb.size() != 0 && k < 100) begin
            @(negedge clk);
            k++;
        end
        check("scoreboard_empty", 32'(sb.size()), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
